// File: rtl/fetch_pkg.sv
// Shared types for the RV32I instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with clear; head data reads as zero while empty.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && !clear && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: credit-limited imem requests, PC-tagged decode buffer, redirect flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [TCW-1:0] drop_cnt_q, drop_cnt_d;

  fetch_entry_t   fifo_wdata, fifo_rdata;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full, fifo_empty;
  logic [31:0]    tag_rdata;
  logic [TCW-1:0] tag_count;
  logic           tag_full, tag_empty;

  logic credit_ok, req_fire, rsp_stale, rsp_live, dec_fire;
  logic rpc_unused;

  assign rpc_unused = ^redirect_pc[1:0];

  // Tag queue holds exactly the live (non-stale) in-flight requests.
  assign credit_ok = (int'(tag_count) + int'(fifo_count) < FIFO_DEPTH) &&
                     (int'(tag_count) + int'(drop_cnt_q) < MAX_OUTSTANDING);

  assign imem_req_valid = (state_q != BOOT) && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_stale = (drop_cnt_q != '0) || redirect_valid;
  assign rsp_live  = imem_rsp_valid && !rsp_stale;

  assign dec_valid = !fifo_empty;
  assign dec_instr = fifo_rdata.instr;
  assign dec_pc    = fifo_rdata.pc;
  assign dec_fire  = dec_valid && dec_ready;

  assign fifo_wdata = '{instr: imem_rsp_data, pc: tag_rdata};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_dec_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_live),
    .wdata (fifo_wdata),
    .pop   (dec_fire),
    .clear (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (rsp_live),
    .clear (redirect_valid),
    .rdata (tag_rdata),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still owed by memory after this cycle becomes stale.
      drop_cnt_d = TCW'(int'(drop_cnt_q) + int'(tag_count) + int'(req_fire)
                        - int'(imem_rsp_valid));
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redirect_valid && drop_cnt_d != '0) state_d = FLUSH;
      FLUSH:   if (!redirect_valid && drop_cnt_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_live && fifo_full && !dec_fire));
      assert (!(req_fire && tag_full && !redirect_valid));
      assert (!(rsp_live && tag_empty));
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flushed_sum;
  logic [31:0] flush_inc;

  // A popped head in the redirect cycle counts as fetched, not flushed.
  always_comb begin
    flush_inc = 32'(imem_rsp_valid && rsp_stale);
    if (redirect_valid)
      flush_inc = flush_inc + 32'(fifo_count) - 32'(dec_fire);
    flushed_sum    = {1'b0, perf_flushed_q} + {1'b0, flush_inc};
    perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
    perf_fetched_d = perf_fetched_q;
    if (dec_fire && perf_fetched_q != 32'hFFFF_FFFF)
      perf_fetched_d = perf_fetched_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with fixed latency, scoreboard on decode pops.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t  sb[$];
  pend_t pend[$];
  exp_t  mon_e;
  int    nvec = 0, nerr = 0;
  int    cyc = 0, lat = 1, budget = 0, accepted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One cycle window, starting 1 time unit after a rising edge.
  task automatic tick(input logic rv = 1'b0, input logic [31:0] rpc = 32'h0);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = (accepted < budget);
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      accepted++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb.push_back('{pc: pc, instr: mem_word(pc)});
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    dec_ready = 1'b0;
    budget    = 0;
    accepted  = 0;
    pend.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every decode pop must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL dec_pop: got unexpected pc %h, want no output", dec_pc);
      end else begin
        mon_e = sb.pop_front();
        if (dec_pc !== mon_e.pc || dec_instr !== mon_e.instr) begin
          nerr++;
          $display("FAIL dec_pop: got pc %h instr %h, want pc %h instr %h",
                   dec_pc, dec_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    // Reset state and free-running fetch of six words.
    do_reset();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    lat = 1; dec_ready = 1'b1; budget = 6;
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    tick();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick_n(25);
    chk("run_accepted", 32'(accepted), 32'd6);
    chk("run_sb_drained", 32'(sb.size()), 32'd0);

    // Decode stalled: two requests fill the buffer, then resume.
    do_reset();
    lat = 1; budget = 100;
    tick_n(10);
    chk("stall_accepted", 32'(accepted), 32'd2);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("stall_dec_pc", dec_pc, 32'h0);
    chk("stall_dec_instr", dec_instr, mem_word(32'h0));
    chk("stall_req_addr", imem_req_addr, 32'h8);
    budget = 4;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
    dec_ready = 1'b1;
    tick_n(15);
    chk("resume_accepted", 32'(accepted), 32'd4);
    chk("resume_sb_drained", 32'(sb.size()), 32'd0);

    // Latency 3, two in flight at 0x10/0x14, redirect to 0x100.
    do_reset();
    lat = 3; dec_ready = 1'b1;
    tick(1'b1, 32'h10);
    budget = 2;
    tick(); tick();
    budget = 5;
    expect_pc(32'h100); expect_pc(32'h104); expect_pc(32'h108);
    tick(1'b1, 32'h100);
    chk("flush_req_addr", imem_req_addr, 32'h100);
    chk("flush_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("flush_dec_valid", {31'b0, dec_valid}, 32'd0);
    tick_n(25);
    chk("flush_accepted", 32'(accepted), 32'd5);
    chk("flush_sb_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_a", perf_fetched, 32'd3);
    chk("perf_flushed_a", perf_flushed, 32'd2);
`endif

    // Redirect coinciding with request 0x20 and response for 0x1C.
    do_reset();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_flushed_rst", perf_flushed, 32'd0);
`endif
    lat = 1; dec_ready = 1'b1;
    tick(1'b1, 32'h1C);
    budget = 1;
    tick();
    chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h20);
    budget = 4;
    expect_pc(32'h200); expect_pc(32'h204);
    tick(1'b1, 32'h203);
    chk("coinc_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("coinc_new_addr", imem_req_addr, 32'h200);
    chk("coinc_new_valid", {31'b0, imem_req_valid}, 32'd1);
    tick_n(15);
    chk("coinc_accepted", 32'(accepted), 32'd4);
    chk("coinc_sb_drained", 32'(sb.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_b", perf_fetched, 32'd2);
    chk("perf_flushed_b", perf_flushed, 32'd2);
`endif

    // PC wraps from 0xFFFF_FFFC to 0.
    do_reset();
    lat = 1;
    tick(1'b1, 32'hFFFF_FFFC);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    budget = 1; dec_ready = 1'b1;
    expect_pc(32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    tick_n(6);
    chk("wrap_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the RV32I core. Holds the architectural fetch PC and issues in-order word requests to instruction memory with a valid/ready handshake. Buffers returned instructions, tagged with their PC, in a small FIFO feeding decode. Accepts redirects from the branch unit's next-address output (iaddr). On a redirect it flushes buffered and in-flight instructions and restarts at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, decode buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max accepted imem requests without response

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address (= fetch_pc)
imem_rsp_valid  input  1  response valid; in order, latency >=1, one per cycle max
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  branch unit redirect (taken branch or jump)
redirect_pc  input  32  new PC from branch unit iaddr; bits[1:0] ignored (forced 0)
dec_valid  output  1  FIFO head valid
dec_ready  input  1  decode consumes head
dec_instr  output  32  head instruction
dec_pc  output  32  PC of head instruction

Behaviour:
- Reset (sync, rst=1 at clk edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=BOOT. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0. Reset mid-operation discards everything. Responses arriving after reset for pre-reset requests are the memory's problem; the memory is reset on the same rst.
- FSM: BOOT -> RUN after one cycle, no request issued in BOOT. RUN -> FLUSH on a redirect while drop_cnt_next>0. FLUSH -> RUN when drop_cnt reaches 0. Redirect in FLUSH stays in FLUSH.
- Credit rule: imem_req_valid=1 in RUN/FLUSH iff (outstanding_live + fifo_count) < FIFO_DEPTH and outstanding_total < MAX_OUTSTANDING.
  - outstanding_live counts non-stale in-flight requests; outstanding_total = outstanding_live + drop_cnt.
  - Both use registered values only; a pop frees credit the following cycle.
- Issue: on imem_req_valid & imem_req_ready, fetch_pc += 4 (32-bit wrap from 0xFFFF_FFFC to 0). The issued PC is pushed into an internal PC-tag queue of depth MAX_OUTSTANDING.
- Response: when not stale, pop the PC-tag queue and push {data, pc} into the FIFO. A space is guaranteed by credit, so overflow is an assertion failure. When drop_cnt>0, discard the response and decrement drop_cnt.
- Decode handshake: pop on dec_valid & dec_ready. Push and pop in the same cycle are both allowed, including full->full and 1->1. A response into an empty FIFO is visible on dec_valid the next cycle (1-cycle buffer latency).
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO cleared (a same-cycle pop still completes); PC-tag queue cleared.
  - drop_cnt <= drop_cnt + outstanding_live + (request handshake this cycle) - (response this cycle).
  - A request handshake in the redirect cycle uses the old PC and is therefore stale.
  - A response in the redirect cycle is discarded.
  - The first request to redirect_pc may issue the next cycle.
- Simultaneous redirect and rst: rst wins.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] (FIFO pops) and perf_flushed[31:0] (discarded responses plus cleared FIFO entries). Both are cleared by rst and saturate at 0xFFFF_FFFF.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fetch_pkg: fetch_state_e {BOOT, RUN, FLUSH}; typedef fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc;}; localparam NOP_INSTR=32'h0000_0013.
- Sub-module: sync_fifo (parameterised width/depth, push/pop/clear, count, full/empty). It is instantiated twice: decode FIFO with fetch_entry_t, PC-tag queue with 32-bit.

Test Plan:
- Reset then free-running memory (ready=1, latency 1, dec_ready=1) -> requests at 0x0,0x4,0x8...; dec_pc sequence 0x0,0x4,0x8 with matching dec_instr; no gaps after fill.
- dec_ready=0 -> at most 2 requests issued, FIFO full, imem_req_valid=0; raise dec_ready -> pops 0x0 then 0x4 and fetching resumes at 0x8.
- Memory latency 3 with 2 requests in flight (PCs 0x10,0x14), redirect_pc=0x100 -> both responses dropped, state FLUSH then RUN, next dec_pc=0x100.
- Redirect in the same cycle as a request handshake at 0x20 and a response for 0x1C -> both discarded, FIFO empty, next request addr 0x200 (redirect_pc=0x203 gives aligned 0x200).
- fetch_pc=0xFFFF_FFFC, issue -> next imem_req_addr=0x0000_0000.
- With FETCH_PERF_CNT_EN: 5 pops and a flush of 2 -> perf_fetched=5, perf_flushed=2; rst clears both.
